sp_ram_arb: RTL

- Two-requester front-end for the single-port byte-strobed RAM.
- Arbitrates valid/ready read/write requests from ports A and B round-robin onto the single RAM port: one access per cycle.
- Drives the RAM address/data/write-enable and captures the RAM's combinational read data into per-port registered response slots with valid/ready.
- Sits directly upstream of the RAM; the RAM's Q output is consumed only by this block.

---
 rtl/sp_ram_arb_pkg.sv | 29 ++
 rtl/sp_ram_arb_rsp_slot.sv | 57 +++++
 rtl/sp_ram_arb.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/sp_ram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sp_ram_arb_pkg
// Shared types for the two-port front-end of the single-port byte-strobed RAM.
//   port_sel_e   : which requester a grant / priority pointer refers to.
//   init_state_e : state of the optional post-reset clearing sweep
//                  (only used when SP_RAM_ARB_INIT_EN is defined).
//   other_port() : the requester that is not the argument; used to rotate
//                  the round-robin pointer.
// The request struct depends on the module parameters (address, data and
// strobe widths), so it is declared as a typedef inside sp_ram_arb, where
// those widths are known.
// -----------------------------------------------------------------------------
package sp_ram_arb_pkg;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_e;

  typedef enum logic {
    INIT_SWEEP = 1'b0,
    INIT_DONE  = 1'b1
  } init_state_e;

  function automatic port_sel_e other_port(input port_sel_e p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/sp_ram_arb_rsp_slot.sv
// -----------------------------------------------------------------------------
// sp_ram_arb_rsp_slot
// One-entry registered read-response slot.
//   clk_i, rst_ni   : clock, asynchronous active-low reset (clears valid and data)
//   load_i          : capture load_data_i this edge (read granted for this port)
//   load_data_i     : combinational RAM read data
//   rsp_ready_i     : consumer accepts the response
//   rsp_valid_o     : slot holds a response
//   rsp_data_o      : response data, stable while rsp_valid_o && !rsp_ready_i
//   free_o          : slot can accept a load this edge (empty, or being drained)
// Handshake: a response transfers on a clock edge where rsp_valid_o and
// rsp_ready_i are both 1. A load on the same edge as a drain refills the slot,
// so back-to-back reads are sustained.
// -----------------------------------------------------------------------------
module sp_ram_arb_rsp_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             rsp_ready_i,
  output logic             rsp_valid_o,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic             free_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = load_data_i;
    end else if (valid_q && rsp_ready_i) begin
      // Data is left in place after a drain; only valid drops.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign rsp_valid_o = valid_q;
  assign rsp_data_o  = data_q;
  assign free_o      = !valid_q || rsp_ready_i;

endmodule

// File: rtl/sp_ram_arb.sv
// -----------------------------------------------------------------------------
// sp_ram_arb
// Round-robin two-requester front-end for a single-port byte-strobed RAM with
// combinational read data. One access (read or write) per cycle.
//   CLK, RST_N              : clock, asynchronous active-low reset
//   {A,B}_REQ_VALID/READY   : request handshake (READY = granted this cycle)
//   {A,B}_REQ_WE/ADDR/D/STRB: request payload (STRB ignored for reads)
//   {A,B}_RSP_VALID/READY/Q : registered read response, one cycle after grant
//   RAM_ADDR/RAM_D/RAM_W_EN : RAM drive, zero when nothing is granted
//   RAM_Q                   : combinational RAM read of RAM_ADDR
// Handshake: a request transfers on a clock edge where REQ_VALID and REQ_READY
// are both 1; a response transfers on an edge where RSP_VALID and RSP_READY are
// both 1. REQ_READY never waits for REQ_VALID except through eligibility.
// Optional feature, macro SP_RAM_ARB_INIT_EN: after reset the RAM is cleared
// by a DEPTH-cycle sweep (addresses 0..DEPTH-1, data 0, all lanes enabled)
// during which both REQ_READY outputs stay 0. The sweep FSM state is
// init_state_q.
// -----------------------------------------------------------------------------
module sp_ram_arb
  import sp_ram_arb_pkg::*;
#(
  parameter  int WIDTH      = 8,
  parameter  int DEPTH      = 8,
  parameter  int STRB_WIDTH = 8,
  localparam int NUM_LANES  = WIDTH / STRB_WIDTH,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 A_REQ_VALID,
  output logic                 A_REQ_READY,
  input  logic                 A_REQ_WE,
  input  logic [ADDR_W-1:0]    A_REQ_ADDR,
  input  logic [WIDTH-1:0]     A_REQ_D,
  input  logic [NUM_LANES-1:0] A_REQ_STRB,
  output logic                 A_RSP_VALID,
  input  logic                 A_RSP_READY,
  output logic [WIDTH-1:0]     A_RSP_Q,
  input  logic                 B_REQ_VALID,
  output logic                 B_REQ_READY,
  input  logic                 B_REQ_WE,
  input  logic [ADDR_W-1:0]    B_REQ_ADDR,
  input  logic [WIDTH-1:0]     B_REQ_D,
  input  logic [NUM_LANES-1:0] B_REQ_STRB,
  output logic                 B_RSP_VALID,
  input  logic                 B_RSP_READY,
  output logic [WIDTH-1:0]     B_RSP_Q,
  output logic [ADDR_W-1:0]    RAM_ADDR,
  output logic [WIDTH-1:0]     RAM_D,
  output logic [NUM_LANES-1:0] RAM_W_EN,
  input  logic [WIDTH-1:0]     RAM_Q
);

  typedef struct packed {
    logic                 we;
    logic [ADDR_W-1:0]    addr;
    logic [WIDTH-1:0]     d;
    logic [NUM_LANES-1:0] strb;
  } req_t;

  req_t      req_a, req_b, req_g;
  logic      a_free, b_free;
  logic      a_elig, b_elig;
  logic      grant_a, grant_b;
  logic      arb_en;
  logic      sweep_active;
  port_sel_e ptr_q, ptr_d;

  assign req_a = '{we: A_REQ_WE, addr: A_REQ_ADDR, d: A_REQ_D, strb: A_REQ_STRB};
  assign req_b = '{we: B_REQ_WE, addr: B_REQ_ADDR, d: B_REQ_D, strb: B_REQ_STRB};

`ifdef SP_RAM_ARB_INIT_EN
  init_state_e       init_state_q, init_state_d;
  logic [ADDR_W-1:0] init_addr_q, init_addr_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      init_state_q <= INIT_SWEEP;
      init_addr_q  <= '0;
    end else begin
      init_state_q <= init_state_d;
      init_addr_q  <= init_addr_d;
    end
  end

  always_comb begin
    init_state_d = init_state_q;
    init_addr_d  = init_addr_q;
    case (init_state_q)
      INIT_SWEEP: begin
        if (init_addr_q == ADDR_W'(DEPTH - 1)) begin
          init_state_d = INIT_DONE;
        end else begin
          init_addr_d = init_addr_q + 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // The sweep is held off while reset is asserted so nothing is written then.
  assign sweep_active = RST_N && (init_state_q == INIT_SWEEP);
  assign arb_en       = RST_N && (init_state_q == INIT_DONE);
`else
  assign sweep_active = 1'b0;
  assign arb_en       = RST_N;
`endif

  // Writes never produce a response, so they ignore the slot state.
  assign a_elig = arb_en && A_REQ_VALID && (A_REQ_WE || a_free);
  assign b_elig = arb_en && B_REQ_VALID && (B_REQ_WE || b_free);

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_elig && b_elig) begin
      grant_a = (ptr_q == PORT_A);
      grant_b = (ptr_q == PORT_B);
    end else begin
      grant_a = a_elig;
      grant_b = b_elig;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_a) begin
      ptr_d = other_port(PORT_A);
    end else if (grant_b) begin
      ptr_d = other_port(PORT_B);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr_q <= PORT_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign A_REQ_READY = grant_a;
  assign B_REQ_READY = grant_b;

  assign req_g = grant_b ? req_b : req_a;

  always_comb begin
    RAM_ADDR = '0;
    RAM_D    = '0;
    RAM_W_EN = '0;
    if (sweep_active) begin
`ifdef SP_RAM_ARB_INIT_EN
      RAM_ADDR = init_addr_q;
`endif
      RAM_W_EN = '1;
    end else if (grant_a || grant_b) begin
      RAM_ADDR = req_g.addr;
      RAM_D    = req_g.d;
      RAM_W_EN = req_g.we ? req_g.strb : '0;
    end
  end

  sp_ram_arb_rsp_slot #(.WIDTH(WIDTH)) u_slot_a (
    .clk_i       (CLK),
    .rst_ni      (RST_N),
    .load_i      (grant_a && !A_REQ_WE),
    .load_data_i (RAM_Q),
    .rsp_ready_i (A_RSP_READY),
    .rsp_valid_o (A_RSP_VALID),
    .rsp_data_o  (A_RSP_Q),
    .free_o      (a_free)
  );

  sp_ram_arb_rsp_slot #(.WIDTH(WIDTH)) u_slot_b (
    .clk_i       (CLK),
    .rst_ni      (RST_N),
    .load_i      (grant_b && !B_REQ_WE),
    .load_data_i (RAM_Q),
    .rsp_ready_i (B_RSP_READY),
    .rsp_valid_o (B_RSP_VALID),
    .rsp_data_o  (B_RSP_Q),
    .free_o      (b_free)
  );

endmodule
